// File: rtl/wb_sim_ctrl_pkg.sv
// Shared definitions for the simulation run-control block.
//   - state_t: run-control FSM states (HOLD -> RUN -> DONE | TIMEOUT)
//   - REG_*  : word offsets in the 16-byte register window (adr[3:2])
//   - STAT_* : bit positions inside the STATUS word
package wb_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [1:0] REG_TOHOST  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CYCLE   = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int STAT_DONE    = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_TIMEOUT = 2;

  function automatic logic [31:0] status_word(input logic timeout, input logic pass,
                                              input logic done);
    logic [31:0] w;
    w               = '0;
    w[STAT_DONE]    = done;
    w[STAT_PASS]    = pass;
    w[STAT_TIMEOUT] = timeout;
    return w;
  endfunction

endpackage

// File: rtl/wb_sim_ctrl_regs.sv
// Wishbone slave front end for wb_sim_ctrl.
//   clk, rst          : clock, asynchronous active-high reset
//   wb_*              : pipelined Wishbone slave (never stalls, one-cycle ack)
//   tohost_rd         : current TOHOST read value {exit_code, done}
//   status_rd         : current STATUS word
//   cycle_rd          : current cycle counter, low 32 bits
//   tohost_wr         : full-word TOHOST write with bit0 set (state check is done by the top)
//   tohost_code       : exit code carried by that write (dat_i[31:1])
// Holds the SCRATCH register with byte-lane writes.
module wb_sim_ctrl_regs
  import wb_sim_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [3:0]            wb_sel,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_stall,
  input  logic [31:0]           tohost_rd,
  input  logic [31:0]           status_rd,
  input  logic [31:0]           cycle_rd,
  output logic                  tohost_wr,
  output logic [30:0]           tohost_code
);

  logic        req_p0;
  logic [1:0]  reg_p0;
  logic [31:0] rd_mux_p0;
  logic [31:0] scratch;
  logic        unused_adr;

  // Request stage: decode the word select; address bits outside adr[3:2] are don't-care.
  assign req_p0     = wb_cyc & wb_stb;
  assign reg_p0     = wb_adr[3:2];
  assign unused_adr = ^wb_adr;
  assign wb_stall   = 1'b0;

  assign tohost_wr   = req_p0 & wb_we & (reg_p0 == REG_TOHOST) & (wb_sel == 4'hF) & wb_dat_i[0];
  assign tohost_code = wb_dat_i[31:1];

  always_comb begin
    rd_mux_p0 = '0;
    case (reg_p0)
      REG_TOHOST:  rd_mux_p0 = tohost_rd;
      REG_STATUS:  rd_mux_p0 = status_rd;
      REG_CYCLE:   rd_mux_p0 = cycle_rd;
      REG_SCRATCH: rd_mux_p0 = scratch;
      default:     rd_mux_p0 = '0;
    endcase
  end

  // Response stage: ack one cycle after the request; read data only travels with a read ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      scratch  <= '0;
    end else begin
      wb_ack   <= req_p0;
      wb_dat_o <= (req_p0 && !wb_we) ? rd_mux_p0 : 32'h0;
      if (req_p0 && wb_we && (reg_p0 == REG_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_sel[b]) scratch[8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/wb_sim_ctrl.sv
// Run-control and end-of-test block for the ibex_wb SoC.
//   clk, rst    : clock, asynchronous active-high reset
//   wb_*        : Wishbone slave (TOHOST / STATUS / CYCLE / SCRATCH)
//   core_rst_n  : active-low reset to core and peripherals, released RESET_CYCLES after rst
//   done, pass  : software wrote TOHOST; pass when exit code is zero
//   timeout     : watchdog expired after TIMEOUT_CYCLES run cycles (0 disables it)
//   exit_code   : tohost[31:1]
//   led         : pass, or a slow blink from the cycle counter while running
module wb_sim_ctrl
  import wb_sim_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 350,
  parameter int CNT_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [3:0]            wb_sel,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_stall,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [30:0]           exit_code,
  output logic                  led
);

  localparam int HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int BLINK_BIT = (CNT_WIDTH > 20) ? 20 : CNT_WIDTH - 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WD_MATCH  =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [CNT_WIDTH-1:0]  cycle;
  logic                  pass_q;
  logic [30:0]           exit_q;
  logic                  core_rst_q;
  logic                  tohost_wr;
  logic [30:0]           tohost_code;
  logic                  tohost_go;
  logic                  wd_hit;
  logic                  hold_done;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hold_done = (hold_cnt == HOLD_LAST);
  assign tohost_go = tohost_wr & (state == ST_RUN);
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && (cycle == WD_MATCH);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: if (hold_done) state_nxt = ST_RUN;
      // A valid TOHOST write outranks a watchdog match in the same cycle.
      ST_RUN: begin
        if (tohost_go)   state_nxt = ST_DONE;
        else if (wd_hit) state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HOLD;
    else     state <= state_nxt;
  end

  // Counter / result stage: updated on the same edge as the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      cycle      <= '0;
      pass_q     <= 1'b0;
      exit_q     <= '0;
      core_rst_q <= 1'b0;
    end else begin
      if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_done) core_rst_q <= 1'b1;
      end
      if (state == ST_RUN) begin
        cycle <= sat_inc(cycle);
        if (tohost_go) begin
          exit_q <= tohost_code;
          pass_q <= (tohost_code == '0);
        end
      end
    end
  end

  assign core_rst_n = core_rst_q;
  assign done       = (state == ST_DONE);
  assign timeout    = (state == ST_TIMEOUT);
  assign pass       = pass_q;
  assign exit_code  = exit_q;
  assign led        = pass_q | ((state == ST_RUN) & cycle[BLINK_BIT]);

  wb_sim_ctrl_regs #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack     (wb_ack),
    .wb_stall   (wb_stall),
    .tohost_rd  ({exit_q, done}),
    .status_rd  (status_word(timeout, pass_q, done)),
    .cycle_rd   (32'(cycle)),
    .tohost_wr  (tohost_wr),
    .tohost_code(tohost_code)
  );

endmodule
